// File: rtl/pll_rst_seq_pkg.sv
// Purpose: shared types and widths for the PLL supervisor / reset sequencer.
//   state_t    : sequencer states
//   RETRY_W    : width of the retry_cnt output
//   LOSS_CNT_W : width of the optional lock-loss counter
package pll_rst_seq_pkg;

  localparam int unsigned RETRY_W    = 4;
  localparam int unsigned LOSS_CNT_W = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } state_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Purpose: two-flop synchroniser for the asynchronous PLL lock signal.
// Ports:
//   clk   in  sampling clock
//   reset in  synchronous active-high reset, clears both flops
//   din   in  asynchronous input
//   dout  out synchronised output, two cycles of latency
module pll_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// Purpose: PLL supervisor and staggered downstream reset sequencer.
//   Holds the PLL in reset, waits for a filtered lock (retrying on timeout),
//   then releases rst_out bits one STAGGER_CYC apart, lowest bit first.
// Ports:
//   clkin         in  free-running reference clock
//   reset         in  synchronous active-high block reset
//   pll_lock      in  raw asynchronous PLL lock
//   soft_rst_req  in  one-cycle request to re-sequence resets (RUN only)
//   pll_reset     out PLL reset, active high
//   rst_out       out NUM_RST active-high downstream resets
//   ready         out high in RUN
//   fail          out high in FAIL (sticky until reset)
//   retry_cnt     out PLL attempts in the current sequence, saturating
// Optional build macro PLL_RST_SEQ_LOSS_CNT_EN adds:
//   lock_loss_cnt out saturating count of lock losses while in RUN
//   last_lock_cyc out WAIT_LOCK timer value at the most recent lock rise
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_RST          = 2,
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_FILT_CYC    = 1024,
  parameter int unsigned STAGGER_CYC      = 64,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  soft_rst_req,
  output logic                  pll_reset,
  output logic [NUM_RST-1:0]    rst_out,
  output logic                  ready,
  output logic                  fail,
`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0]      last_lock_cyc,
`endif
  output logic [RETRY_W-1:0]    retry_cnt
);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   FILT_LAST = CNT_W'(LOCK_FILT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     timer, timer_nx;
  logic [NUM_RST-1:0]   rst_nx;
  logic [RETRY_W-1:0]   retry_nx, retry_inc;
  logic                 pll_reset_nx, ready_nx, fail_nx;
  logic                 lk;

  // Lock synchroniser
  pll_lock_sync u_sync (
    .clk   (clkin),
    .reset (reset),
    .din   (pll_lock),
    .dout  (lk)
  );

  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);

  // Next-state, timer and output decode
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    rst_nx   = rst_out;
    retry_nx = retry_cnt;

    case (state)
      PLL_RST: begin
        rst_nx = '1;
        if (timer == RST_LAST) begin
          state_nx = WAIT_LOCK;
          timer_nx = '0;
          retry_nx = retry_inc;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end

      // Lock is checked before the timeout so a coincident rise wins
      WAIT_LOCK: begin
        if (lk) begin
          state_nx = FILTER;
          timer_nx = '0;
        end else if (timer == TO_LAST) begin
          state_nx = (retry_cnt < RETRY_MAX) ? PLL_RST : FAIL;
          timer_nx = '0;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end

      FILTER: begin
        if (!lk) begin
          state_nx = WAIT_LOCK;
          timer_nx = '0;
        end else if (timer == FILT_LAST) begin
          state_nx  = RELEASE;
          timer_nx  = '0;
          rst_nx[0] = 1'b0;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end

      // Timer counts cycles since entry; bit i drops when it reaches i*STAGGER_CYC
      RELEASE: begin
        if (!lk) begin
          state_nx = PLL_RST;
          timer_nx = '0;
          rst_nx   = '1;
        end else if (rst_out == '0) begin
          state_nx = RUN;
          timer_nx = '0;
        end else begin
          timer_nx = timer + CNT_W'(1);
          for (int i = 1; i < int'(NUM_RST); i++) begin
            if (timer_nx == CNT_W'(i * int'(STAGGER_CYC))) rst_nx[i] = 1'b0;
          end
        end
      end

      RUN: begin
        rst_nx = '0;
        if (!lk) begin
          state_nx = PLL_RST;
          timer_nx = '0;
          rst_nx   = '1;
          retry_nx = '0;
        end else if (soft_rst_req) begin
          state_nx = FILTER;
          timer_nx = '0;
          rst_nx   = '1;
        end
      end

      FAIL: begin
        rst_nx = '1;
      end

      default: begin
        state_nx = PLL_RST;
        timer_nx = '0;
        rst_nx   = '1;
      end
    endcase

    pll_reset_nx = (state_nx == PLL_RST) || (state_nx == FAIL);
    ready_nx     = (state_nx == RUN);
    fail_nx      = (state_nx == FAIL);
  end

  // State and registered outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= PLL_RST;
      timer     <= '0;
      pll_reset <= 1'b1;
      rst_out   <= '1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      pll_reset <= pll_reset_nx;
      rst_out   <= rst_nx;
      ready     <= ready_nx;
      fail      <= fail_nx;
      retry_cnt <= retry_nx;
    end
  end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
  // Lock-loss statistics
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_loss_cnt <= '0;
      last_lock_cyc <= '0;
    end else begin
      if ((state == RUN) && !lk && (lock_loss_cnt != '1))
        lock_loss_cnt <= lock_loss_cnt + LOSS_CNT_W'(1);
      if ((state == WAIT_LOCK) && lk)
        last_lock_cyc <= timer;
    end
  end
`endif

endmodule
